// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, redirect/stall handling.
// Optional performance counters are built when MIPS_FETCH_PERF_EN is defined.
module mips_fetch_stage #(
  parameter int unsigned           PC_W     = 32,
  parameter logic [PC_W-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc_addr,
  input  logic [31:0]     instr,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic [PC_W-1:0] if_id_pc_next,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_stall_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            active_c;
  logic            bubble_c;
  logic            stall_c;
  logic            fetch_c;

  assign pc_addr = pc;

  // Edge classification: redirect beats stall beats normal fetch; BOOT does nothing.
  assign active_c = (state != BOOT);
  assign bubble_c = active_c & redirect;
  assign stall_c  = active_c & ~redirect & stall;
  assign fetch_c  = active_c & ~redirect & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      if_id_valid   <= 1'b0;
      if_id_instr   <= 32'h0;
      if_id_pc      <= '0;
      if_id_pc_next <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        default: begin
          if (bubble_c) begin
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            state       <= RUN;
          end else if (stall_c) begin
            state <= HOLD;
          end else begin
            if_id_valid   <= 1'b1;
            if_id_instr   <= instr;
            if_id_pc      <= pc;
            if_id_pc_next <= pc + PC_W'(1);
            pc            <= pc + PC_W'(1);
            state         <= RUN;
          end
        end
      endcase
    end
  end

`ifdef MIPS_FETCH_PERF_EN
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (fetch_c)  fetch_cnt  <= fetch_cnt  + CNT_W'(1);
      if (bubble_c) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (stall_c)  stall_cnt  <= stall_cnt  + CNT_W'(1);
    end
  end

  assign perf_fetch_cnt  = fetch_cnt;
  assign perf_bubble_cnt = bubble_cnt;
  assign perf_stall_cnt  = stall_cnt;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
  assign perf_stall_cnt  = 32'h0;
`endif

endmodule
